// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered 8N1 UART transmitter.
// Combinational only; no latency or backpressure.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        START,
        DATA,
        STOP
    } state_t;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Upstream-buffer read port plus serial/status outputs of the transmitter.
// Wiring only; the read strobe has one-cycle data latency, and tx_en/empty_flag gate fetching.
interface fifo_uart_tx_if;
    import uart_pkg::*;

    logic              tx_en;
    logic              empty_flag;
    logic [DATA_W-1:0] data_in;
    logic              en_r;
    logic              tx;
    logic              busy;
    logic              frame_done;

    modport master (
        output tx_en, empty_flag, data_in,
        input  en_r, tx, busy, frame_done
    );

    modport slave (
        input  tx_en, empty_flag, data_in,
        output en_r, tx, busy, frame_done
    );

endinterface

// File: rtl/baud_counter.sv
// Free-running bit-period counter; tick is high on the last cycle of each period.
// A clear restarts the period from zero on the next cycle; no backpressure.
module baud_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pulls bytes from an upstream buffer and serialises them as 8N1, LSB first.
// 3 cycles from fetch decision to start bit; frames are 10 bit periods; tx_en/empty_flag hold off fetching.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = uart_pkg::DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.slave  bus
);

    // Index of the last data bit: frame minus start and stop, zero-based.
    localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

    state_t            state, nxt;
    logic [DATA_W-1:0] sh, sh_n;
    logic [2:0]        bit_cnt, bit_n;
    logic              armed;
    logic              tick;
    logic              clear;
    logic              tx_d;

    baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    // armed holds off the first fetch until one full cycle after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sh      <= '0;
            bit_cnt <= '0;
            armed   <= 1'b0;
            bus.tx  <= 1'b1;
        end else begin
            state   <= nxt;
            sh      <= sh_n;
            bit_cnt <= bit_n;
            armed   <= 1'b1;
            bus.tx  <= tx_d;
        end
    end

    always_comb begin
        nxt   = state;
        sh_n  = sh;
        bit_n = bit_cnt;
        unique case (state)
            IDLE: begin
                if (armed && bus.tx_en && !bus.empty_flag) begin
                    nxt = FETCH;
                end
            end
            FETCH: nxt = WAIT;
            WAIT: begin
                sh_n = bus.data_in;
                nxt  = START;
            end
            START: begin
                if (tick) begin
                    nxt   = DATA;
                    bit_n = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        nxt = STOP;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                        sh_n  = sh >> 1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // tx is registered from the upcoming state so the line changes exactly on state entry.
    always_comb begin
        tx_d = 1'b1;
        if (nxt == START) begin
            tx_d = 1'b0;
        end else if (nxt == DATA) begin
            tx_d = sh_n[0];
        end
    end

    assign clear          = (nxt != state);
    assign bus.en_r       = (state == FETCH);
    assign bus.busy       = (state != IDLE);
    assign bus.frame_done = (state == STOP) && tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboarded bench: byte buffer model feeds the transmitter, a serial monitor decodes frames.
// Expected bytes are queued at stimulus time and popped when a complete frame is observed.
module tb_fifo_uart_tx;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    byte unsigned mem[$];
    byte unsigned exp_q[$];

    int frames_done = 0;
    int starts      = 0;
    int enr_cnt     = 0;
    int fd_total    = 0;
    int last_gap    = -1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic put(input byte unsigned b);
        mem.push_back(b);
        exp_q.push_back(b);
    endtask

    // Upstream buffer: data appears the cycle after the read strobe.
    initial begin
        logic rd;
        bus.data_in    = '0;
        bus.empty_flag = 1'b1;
        forever begin
            @(negedge clk);
            rd = bus.en_r;
            @(posedge clk);
            #1;
            if (rd) begin
                check("rd_nonempty", int'(mem.size() > 0), 1);
                if (mem.size() > 0) bus.data_in = mem.pop_front();
            end
            bus.empty_flag = (mem.size() == 0);
        end
    end

    // Serial monitor
    logic [FRAME-1:0] txs;
    int   idx        = 0;
    bit   in_frame   = 1'b0;
    int   gap_cnt    = -1;
    int   fd_pos     = -1;
    int   fd_cnt     = 0;
    int   busy_low   = 0;
    logic prev_enr   = 1'b0;
    logic prev_txen  = 1'b0;
    logic prev_empty = 1'b1;

    task automatic finish_frame();
        logic [9:0]   want;
        logic [9:0]   got;
        int           unstable;
        byte unsigned b;
        unstable = 0;
        got      = '0;
        check("frame_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() == 0) return;
        b    = exp_q.pop_front();
        want = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            got[k] = txs[k*CPB + CPB/2];
            for (int j = 0; j < CPB; j++) begin
                if (txs[k*CPB + j] !== got[k]) unstable++;
            end
        end
        check("frame_bits", int'(got), int'(want));
        check("bit_stable", unstable, 0);
        check("frame_done_cnt", fd_cnt, 1);
        check("frame_done_pos", fd_pos, FRAME - 1);
        check("busy_in_frame", busy_low, 0);
        frames_done++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (in_frame) begin
                    in_frame = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                gap_cnt = -1;
            end else begin
                if (bus.frame_done) fd_total++;
                if (bus.en_r) begin
                    enr_cnt++;
                    check("en_r_cause", int'({prev_enr, prev_txen, prev_empty}), 2);
                end
                if (!in_frame && bus.tx == 1'b0) begin
                    in_frame = 1'b1;
                    idx      = 0;
                    fd_cnt   = 0;
                    fd_pos   = -1;
                    busy_low = 0;
                    last_gap = gap_cnt;
                    starts++;
                end else if (!in_frame && gap_cnt >= 0) begin
                    gap_cnt++;
                end
                if (in_frame) begin
                    txs[idx] = bus.tx;
                    if (bus.frame_done) begin
                        fd_cnt++;
                        fd_pos = idx;
                    end
                    if (!bus.busy) busy_low++;
                    idx++;
                    if (idx == FRAME) begin
                        finish_frame();
                        in_frame = 1'b0;
                        gap_cnt  = 0;
                    end
                end
            end
            prev_enr   = bus.en_r;
            prev_txen  = bus.tx_en;
            prev_empty = bus.empty_flag;
        end
    end

    task automatic wait_frames(input int n, input int budget);
        int c;
        c = 0;
        while (frames_done < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("frames_reached", int'(frames_done >= n), 1);
    endtask

    task automatic wait_start(input int s0, input int budget);
        int c;
        c = 0;
        while (starts <= s0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        check("start_seen", int'(starts > s0), 1);
    endtask

    task automatic quiet_window(input string name, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.en_r !== 1'b0) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int f0;
        int e0;
        int s0;
        int n;

        bus.tx_en = 1'b0;
        rst       = 1'b1;

        // Reset held for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_outputs", int'({bus.tx, bus.en_r, bus.busy, bus.frame_done}), 4'b1000);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte
        e0 = enr_cnt;
        put(8'hA5);
        bus.tx_en = 1'b1;
        wait_frames(1, 400);
        check("enr_single", enr_cnt - e0, 1);

        // Back-to-back bytes, 3-cycle inter-frame gap
        f0 = frames_done;
        e0 = enr_cnt;
        put(8'hA5);
        put(8'h5A);
        wait_frames(f0 + 2, 800);
        check("gap_cycles", last_gap, 3);
        check("enr_pair", enr_cnt - e0, 2);

        // Random bytes with random spacing
        f0 = frames_done;
        for (int i = 0; i < 8; i++) begin
            put(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 200)) @(posedge clk);
            #1;
        end
        wait_frames(f0 + 8, 3000);

        // Empty buffer with tx_en high
        e0 = enr_cnt;
        quiet_window("empty_idle", 200);
        check("enr_empty", enr_cnt - e0, 0);

        // Reset in DATA bit 3 of 0x5A
        s0 = starts;
        put(8'h5A);
        wait_start(s0, 100);
        repeat (70) @(posedge clk);
        #3;
        check("busy_pre_reset", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("reset_abort", int'({bus.tx, bus.busy}), 2'b10);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        e0 = enr_cnt;
        quiet_window("post_abort_idle", 60);
        check("enr_post_abort", enr_cnt - e0, 0);

        // First fetch after reset release with data already waiting
        @(posedge clk);
        #1;
        rst = 1'b1;
        put(8'h3C);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.en_r) break;
        end
        check("fetch_seen", int'(bus.en_r), 1);
        check("fetch_not_early", int'(n >= 3), 1);
        f0 = frames_done;
        wait_frames(f0 + 1, 400);

        // tx_en dropped mid-frame
        f0 = frames_done;
        e0 = enr_cnt;
        s0 = starts;
        put(8'hA5);
        put(8'h5A);
        wait_start(s0, 100);
        repeat (40) @(posedge clk);
        #1;
        bus.tx_en = 1'b0;
        wait_frames(f0 + 1, 400);
        repeat (100) @(posedge clk);
        #1;
        check("enr_held_off", enr_cnt - e0, 1);
        check("idle_held_off", int'({bus.tx, bus.busy}), 2'b10);
        bus.tx_en = 1'b1;
        wait_frames(f0 + 2, 400);
        check("enr_resumed", enr_cnt - e0, 2);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        check("frame_done_total", fd_total, frames_done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
